// File: rtl/switch_input_debouncer.sv
// Board DIP-switch front end: per-pin two-flop synchroniser, per-pin debounce,
// sticky change register with clear-on-read, and a combinational halfword read port.
module switch_input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        switch_cs,
    input  logic        ioread,
    input  logic [2:0]  switch_addr,
    input  logic [23:0] switch_pins,
    output logic [15:0] switch_rdata
);

    localparam int unsigned N_PINS = 24;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_PINS-1:0] sync1_q, sync2_q;
    logic [N_PINS-1:0] stable_q, stable_d;
    logic [N_PINS-1:0] changed_q, changed_d;
    logic [N_PINS-1:0] toggle;
    logic [CNT_W-1:0]  cnt_q [N_PINS];
    logic [CNT_W-1:0]  cnt_d [N_PINS];

    logic rd, clr_lo, clr_hi;

    assign rd     = switch_cs & ioread;
    assign clr_lo = rd && (switch_addr inside {3'b100, 3'b101});
    assign clr_hi = rd && (switch_addr inside {3'b110, 3'b111});

    // Per-bit debounce and change tracking; a toggle on the clearing edge survives.
    always_comb begin
        stable_d  = stable_q;
        changed_d = changed_q;
        toggle    = '0;
        cnt_d     = cnt_q;
        for (int k = 0; k < N_PINS; k++) begin
            if (sync2_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_LAST) begin
                stable_d[k] = sync2_q[k];
                cnt_d[k]    = '0;
                toggle[k]   = 1'b1;
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
        if (clr_lo) changed_d[15:0]  = '0;
        if (clr_hi) changed_d[23:16] = '0;
        changed_d = changed_d | toggle;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            changed_q <= '0;
            for (int k = 0; k < N_PINS; k++) cnt_q[k] <= '0;
        end else begin
            sync1_q   <= switch_pins;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            for (int k = 0; k < N_PINS; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    // Zero-latency read mux; idle bus reads as zero rather than Z.
    always_comb begin
        switch_rdata = 16'h0000;
        if (rd) begin
            case (switch_addr)
                3'b000, 3'b001: switch_rdata = stable_q[15:0];
                3'b010, 3'b011: switch_rdata = {8'h00, stable_q[23:16]};
                3'b100, 3'b101: switch_rdata = changed_q[15:0];
                default:        switch_rdata = {8'h00, changed_q[23:16]};
            endcase
        end
    end

endmodule

// File: tb/tb_switch_input_debouncer.sv
// Directed bench for switch_input_debouncer (DEBOUNCE_CYCLES=4); expected read data is
// queued by the stimulus and checked by an independent negedge monitor.
module tb_switch_input_debouncer;

    logic        clock = 1'b0;
    logic        reset;
    logic        switch_cs;
    logic        ioread;
    logic [2:0]  switch_addr;
    logic [23:0] switch_pins;
    logic [15:0] switch_rdata;

    int total = 0;
    int bad   = 0;
    logic        chk = 1'b0;
    logic [15:0] exp_q [$];
    string       name_q [$];
    logic [15:0] mon_exp;
    string       mon_name;

    switch_input_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .switch_cs    (switch_cs),
        .ioread       (ioread),
        .switch_addr  (switch_addr),
        .switch_pins  (switch_pins),
        .switch_rdata (switch_rdata)
    );

    always #5 clock = ~clock;

    // Monitor: whenever a read is presented, pop the next expectation and compare.
    always @(negedge clock) begin
        if (chk) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read: got %h with empty scoreboard", switch_rdata);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (switch_rdata !== mon_exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", mon_name, switch_rdata, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Non-clearing read: rd dropped before the next rising edge, then realign to posedge+1.
    task automatic peek(input logic cs, input logic [2:0] a, input logic [15:0] e, input string nm);
        switch_cs   = cs;
        ioread      = 1'b1;
        switch_addr = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk = 1'b1;
        @(negedge clock);
        #1;
        chk       = 1'b0;
        switch_cs = 1'b0;
        ioread    = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // One-cycle read held across a rising edge (clears change bits when sel=1x).
    task automatic rd_cycle(input logic [2:0] a, input logic [15:0] e, input string nm);
        switch_cs   = 1'b1;
        ioread      = 1'b1;
        switch_addr = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk = 1'b1;
        @(negedge clock);
        #1;
        chk = 1'b0;
        @(posedge clock);
        #1;
        switch_cs = 1'b0;
        ioread    = 1'b0;
    endtask

    task automatic direct(input string nm, input logic [31:0] act, input logic [31:0] e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        switch_cs   = 1'b0;
        ioread      = 1'b0;
        switch_addr = 3'b000;
        switch_pins = 24'hFFFFFF;
        #1 reset = 1'b0;

        // Reset state and latency with all pins high through release
        peek(1'b1, 3'b000, 16'h0000, "rst_sel00");
        peek(1'b1, 3'b010, 16'h0000, "rst_sel01");
        peek(1'b1, 3'b100, 16'h0000, "rst_sel10");
        peek(1'b1, 3'b110, 16'h0000, "rst_sel11");
        reset = 1'b1;
        for (int e = 0; e < 9; e++)
            peek(1'b1, 3'b000, (e >= 6) ? 16'hFFFF : 16'h0000, $sformatf("latency_e%0d", e));
        peek(1'b1, 3'b010, 16'h00FF, "lat_sel01");
        peek(1'b1, 3'b100, 16'hFFFF, "lat_sel10");
        peek(1'b1, 3'b110, 16'h00FF, "lat_sel11");

        // Glitch rejection from a clean zero state
        switch_pins = 24'h000000;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        switch_pins = 24'h000001;
        repeat (3) tick();
        switch_pins = 24'h000000;
        repeat (6) tick();
        peek(1'b1, 3'b000, 16'h0000, "glitch_stable");
        peek(1'b1, 3'b100, 16'h0000, "glitch_chg_lo");
        peek(1'b1, 3'b110, 16'h0000, "glitch_chg_hi");
        direct("glitch_cnt0", 32'(dut.cnt_q[0]), 32'd0);

        // Register map
        switch_pins = 24'hA51234;
        repeat (8) tick();
        peek(1'b1, 3'b000, 16'h1234, "map_000");
        peek(1'b1, 3'b001, 16'h1234, "map_001");
        peek(1'b1, 3'b010, 16'h00A5, "map_010");
        peek(1'b1, 3'b011, 16'h00A5, "map_011");
        peek(1'b0, 3'b000, 16'h0000, "map_cs0");

        // Clear-on-read
        rd_cycle(3'b100, 16'h1234, "clr_first");
        peek(1'b1, 3'b100, 16'h0000, "clr_second");
        peek(1'b1, 3'b110, 16'h00A5, "clr_hi_kept");
        rd_cycle(3'b110, 16'h00A5, "clr_hi_read");
        peek(1'b1, 3'b110, 16'h0000, "clr_hi_after");

        // Set/clear collision: bit 3 completes on the clearing edge
        switch_pins = 24'hA5123C;
        repeat (5) tick();
        rd_cycle(3'b100, 16'h0000, "coll_read");
        peek(1'b1, 3'b100, 16'h0008, "coll_after");
        peek(1'b1, 3'b000, 16'h123C, "coll_stable");

        // Reset mid-debounce on bit 5
        switch_pins = 24'h000000;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        switch_pins = 24'h000020;
        repeat (5) tick();
        direct("mid_cnt5", 32'(dut.cnt_q[5]), 32'd3);
        direct("mid_stable", 32'(dut.stable_q), 32'd0);
        reset = 1'b0;
        #1;
        direct("rst_stable_now", 32'(dut.stable_q), 32'd0);
        direct("rst_changed_now", 32'(dut.changed_q), 32'd0);
        direct("rst_cnt5_now", 32'(dut.cnt_q[5]), 32'd0);
        peek(1'b1, 3'b000, 16'h0000, "rst_mid_rd");
        reset = 1'b1;
        for (int e = 0; e < 8; e++)
            peek(1'b1, 3'b000, (e >= 6) ? 16'h0020 : 16'h0000, $sformatf("rel_e%0d", e));
        peek(1'b1, 3'b100, 16'h0020, "rel_changed");

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_input_debouncer.md
# switch_input_debouncer

Board-switch front end for the I/O read path. It samples the 24 raw DIP-switch pins, synchronises and debounces each one, and keeps a sticky per-bit change register. It returns a 16-bit halfword to the memory/IO mux's `ioread_data` input when the switch chip-select and I/O-read are both active. Reads of the change halfwords clear the bits they return.

## Interface
- `DEBOUNCE_CYCLES`, default 200000: consecutive clocks a synchronised pin must differ from its stable value before the stable value is updated. Legal range is at least 2.
- `CNT_W`, default 18: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; release is used synchronously.
- `switch_cs`  in  1  switch chip-select (SwitchCtrl from the memory/IO mux).
- `ioread`  in  1  I/O read strobe from control.
- `switch_addr`  in  3  `address[2:0]` of the access. Bit 0 is ignored (halfword aligned).
- `switch_pins`  in  24  raw, asynchronous board switch pins.
- `switch_rdata`  out  16  read halfword, feeding `ioread_data`.

## Operation
- Read select is `rd = switch_cs & ioread`. Register select is `sel = switch_addr[2:1]`.
- `switch_rdata` is combinational:
  - `rd=0`: 16'h0000. The block never drives Z.
  - `sel=00`: `stable[15:0]`.
  - `sel=01`: {8'h00, `stable[23:16]`}.
  - `sel=10`: `changed[15:0]`.
  - `sel=11`: {8'h00, `changed[23:16]`}.
- Synchroniser: two flops per pin, `sync1 <= switch_pins`, then `sync2 <= sync1`.
- Per-bit debounce, evaluated on each edge using pre-edge values, independently for each bit k:
  - If `sync2[k] == stable[k]`: `cnt[k] <= 0`.
  - Else if `cnt[k] == DEBOUNCE_CYCLES-1`: `stable[k] <= sync2[k]`, `cnt[k] <= 0`, and `changed[k]` is set.
  - Else: `cnt[k] <= cnt[k]+1`.
- Any return of `sync2[k]` to `stable[k]` restarts that bit's count, so glitches shorter than `DEBOUNCE_CYCLES` are fully rejected.
- Change register, per edge:
  - If `rd` and `sel=10`: `changed[15:0]` is cleared.
  - If `rd` and `sel=11`: `changed[23:16]` is cleared.
  - A set caused by a stable toggle in the same edge wins over the clear, so no toggle is lost.
- Reads of `sel=00` and `sel=01` have no side effects.
- A multi-cycle read (`rd` held) clears on every edge it is held. The returned data is what was visible before each edge.

## Timing
- Reset state (while `reset=0`):
  - `sync1`, `sync2`, `stable`, `cnt` and `changed` are all 0.
  - `switch_rdata` is 16'h0000 for every `sel`.
- Latency: a pin that changes before edge 1 and holds has `sync2` updated at edge 2 and `stable` updated at edge 2+`DEBOUNCE_CYCLES`. The new value is visible on `switch_rdata` combinationally right after that edge.
- `changed[k]` sets on the same edge as `stable[k]`.
- Read data has zero-cycle latency relative to `rd`/`switch_addr`, compatible with a single-cycle CPU.
- Reset asserted mid-debounce discards partial counts. After release, debounce restarts from `stable=0`.
- Pins that are high at reset release therefore produce `changed` bits once debounced. This is intended: software clears `changed` at boot.
- Counter wrap is impossible: `cnt` never exceeds `DEBOUNCE_CYCLES-1`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- Reset/latency:
  - Stimulus: `switch_pins=24'hFFFFFF` held through reset release; read `sel=00` each cycle.
  - Required: 16'h0000 through edge 5 after release, 16'hFFFF from edge 6 on.
  - Also required: `sel=01` gives 16'h00FF and `sel=10` gives 16'hFFFF.
- Glitch rejection:
  - Stimulus: `stable` settled at 0; pulse bit 0 high for 3 clocks, then low.
  - Required: `stable[0]` stays 0, `changed` stays 24'h0, and `cnt[0]` returns to 0.
- Register map:
  - Stimulus: pins 24'hA51234 settled.
  - Required: `addr=3'b000` gives 16'h1234; `addr=3'b001` gives 16'h1234 (bit 0 ignored); `addr=3'b010` gives 16'h00A5.
  - Required: `rd=0` gives 16'h0000.
- Clear-on-read:
  - Stimulus: after the map test, a one-cycle read of `sel=10`, then `sel=10` again.
  - Required: first read returns 16'h1234, second read returns 16'h0000, and `changed[23:16]` still reads 16'h00A5.
- Set/clear collision:
  - Stimulus: arrange for bit 3's debounce to complete on the same edge as a `sel=10` read.
  - Required: the following `sel=10` read returns 16'h0008.
- Reset mid-debounce:
  - Stimulus: bit 5 toggles at edge 3 of its 4-edge count; assert `reset` for 1 cycle, then release.
  - Required: `stable=0` and `changed=0` immediately on assertion.
  - Required: `stable[5]=1` exactly 6 edges after release.
